// File: rtl/fir_sequencer.sv
// Sequencer for the transposed-form FIR tap chain: coefficient load, chain clear, sample admission.
// Optional FIR_SEQ_SAMPLE_COUNT_EN adds a 32-bit count of output strobes (ov_sample_count).
module fir_sequencer #(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_TAPS   = 16,
    parameter int unsigned IDX_WIDTH  = 4
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_load_start,
    input  logic                           i_coef_valid,
    input  logic [DATA_WIDTH-1:0]          iv_coef,
    output logic                           o_coef_ready,
    input  logic                           i_din_valid,
    input  logic [DATA_WIDTH-1:0]          iv_din,
    output logic                           o_din_ready,
    output logic                           o_tap_en,
    output logic                           o_tap_rst,
    output logic [DATA_WIDTH-1:0]          ov_tap_din,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
    input  logic [DATA_WIDTH-1:0]          iv_chain_sum,
    output logic                           o_dout_valid,
    output logic [DATA_WIDTH-1:0]          ov_dout
`ifdef FIR_SEQ_SAMPLE_COUNT_EN
    ,
    output logic [31:0]                    ov_sample_count
`endif
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoad  = 3'd1;
    localparam logic [2:0] StClear = 3'd2;
    localparam logic [2:0] StRun   = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    logic [2:0]            state_q, state_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [DATA_WIDTH-1:0] weight_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0] tap_din_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  v1_q, v2_q, dout_valid_q;
    logic                  coef_acc, din_acc, last_word;

    // Ready signals are pure state decodes so no input reaches them combinationally.
    assign o_coef_ready = (state_q == StLoad);
    assign o_din_ready  = (state_q == StRun);
    assign o_tap_rst    = (state_q == StClear);

    assign coef_acc  = i_coef_valid && o_coef_ready;
    assign din_acc   = i_din_valid && o_din_ready;
    assign last_word = (idx_q == IDX_WIDTH'(NUM_TAPS - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (i_load_start) state_d = StLoad;
            end
            StLoad: begin
                if (coef_acc) begin
                    idx_d = idx_q + 1'b1;
                    if (last_word) state_d = StClear;
                end
            end
            StClear: begin
                idx_d   = '0;
                state_d = StRun;
            end
            StRun: begin
                if (i_load_start) state_d = StDrain;
            end
            StDrain: begin
                if (!v1_q && !v2_q) state_d = StLoad;
            end
            default: state_d = StIdle;
        endcase
    end

    // v1 drives the tap enable; v2 marks the cycle in which iv_chain_sum holds a fresh result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            tap_din_q    <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            v1_q         <= din_acc;
            v2_q         <= v1_q;
            dout_valid_q <= v2_q;
            if (din_acc) tap_din_q <= iv_din;
            if (v2_q) dout_q <= iv_chain_sum;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int unsigned k = 0; k < NUM_TAPS; k++) begin
            if (i_rst) begin
                weight_q[k] <= '0;
            end else if (coef_acc && (idx_q == IDX_WIDTH'(k))) begin
                weight_q[k] <= iv_coef;
            end
        end
    end

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_weights
        assign ov_weights[g*DATA_WIDTH +: DATA_WIDTH] = weight_q[g];
    end

    assign o_tap_en     = v1_q;
    assign ov_tap_din   = tap_din_q;
    assign o_dout_valid = dout_valid_q;
    assign ov_dout      = dout_q;

`ifdef FIR_SEQ_SAMPLE_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge i_clk) begin
        if (i_rst || (state_q == StClear)) begin
            count_q <= '0;
        end else if (dout_valid_q) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign ov_sample_count = count_q;
`endif

endmodule

// File: tb/tb_fir_sequencer.sv
// Self-checking bench for fir_sequencer: directed vector tables, hand sequences and a random
// phase scored against a convolution reference model; a small tap-chain model feeds iv_chain_sum.
module tb_fir_sequencer;

    localparam int DW = 8;
    localparam int NT = 4;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_load_start = 1'b0;
    logic              i_coef_valid = 1'b0;
    logic [DW-1:0]     iv_coef = '0;
    logic              o_coef_ready;
    logic              i_din_valid = 1'b0;
    logic [DW-1:0]     iv_din = '0;
    logic              o_din_ready;
    logic              o_tap_en;
    logic              o_tap_rst;
    logic [DW-1:0]     ov_tap_din;
    logic [NT*DW-1:0]  ov_weights;
    logic [DW-1:0]     iv_chain_sum;
    logic              o_dout_valid;
    logic [DW-1:0]     ov_dout;
`ifdef FIR_SEQ_SAMPLE_COUNT_EN
    logic [31:0]       ov_sample_count;
`endif

    int checks = 0;
    int errors = 0;
    int rst_pulses = 0;

    fir_sequencer #(
        .DATA_WIDTH(DW),
        .NUM_TAPS  (NT),
        .IDX_WIDTH (2)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load_start(i_load_start),
        .i_coef_valid(i_coef_valid),
        .iv_coef     (iv_coef),
        .o_coef_ready(o_coef_ready),
        .i_din_valid (i_din_valid),
        .iv_din      (iv_din),
        .o_din_ready (o_din_ready),
        .o_tap_en    (o_tap_en),
        .o_tap_rst   (o_tap_rst),
        .ov_tap_din  (ov_tap_din),
        .ov_weights  (ov_weights),
        .iv_chain_sum(iv_chain_sum),
        .o_dout_valid(o_dout_valid),
        .ov_dout     (ov_dout)
`ifdef FIR_SEQ_SAMPLE_COUNT_EN
        ,
        .ov_sample_count(ov_sample_count)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Tap array stand-in: Q-format taps, product scaled down by 2**DW.
    function automatic logic [DW-1:0] prod(input logic signed [DW-1:0] x,
                                           input logic signed [DW-1:0] w);
        logic signed [2*DW-1:0] p;
        p = x * w;
        return p[2*DW-1:DW];
    endfunction

    logic [DW-1:0] tap_sum [NT];

    always @(posedge i_clk) begin
        if (i_rst || o_tap_rst) begin
            for (int k = 0; k < NT; k++) tap_sum[k] <= '0;
        end else if (o_tap_en) begin
            for (int k = 0; k < NT - 1; k++) begin
                tap_sum[k] <= tap_sum[k+1] + prod(ov_tap_din, ov_weights[k*DW +: DW]);
            end
            tap_sum[NT-1] <= prod(ov_tap_din, ov_weights[(NT-1)*DW +: DW]);
        end
    end

    assign iv_chain_sum = tap_sum[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: y[n] = sum_k x[n-k]*w[k] / 2**DW over samples since the last clear.
    logic [DW-1:0]        model_w [NT];
    int                   widx = 0;
    logic signed [DW-1:0] hist [$];
    logic [DW-1:0]        exp_q [$];

    initial begin
        int acc;
        logic [DW-1:0] e;
        for (int k = 0; k < NT; k++) model_w[k] = '0;
        forever begin
            @(negedge i_clk);
            if (o_tap_rst === 1'b1) rst_pulses++;
            if (i_rst === 1'b1) begin
                exp_q.delete();
                hist.delete();
                for (int k = 0; k < NT; k++) model_w[k] = '0;
                widx = 0;
            end else begin
                if (o_dout_valid === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dout_strobe: got strobe with value %0d, expected none",
                                 ov_dout);
                    end else begin
                        e = exp_q.pop_front();
                        check("dout", {24'd0, ov_dout}, {24'd0, e});
                    end
                end
                if (o_tap_rst === 1'b1) hist.delete();
                if (i_coef_valid && o_coef_ready === 1'b1) begin
                    model_w[widx] = iv_coef;
                    widx = (widx == NT - 1) ? 0 : widx + 1;
                end
                if (i_din_valid && o_din_ready === 1'b1) begin
                    hist.push_front(iv_din);
                    if (hist.size() > NT) void'(hist.pop_back());
                    acc = 0;
                    for (int k = 0; k < hist.size(); k++) begin
                        acc += (int'(hist[k]) * int'($signed(model_w[k]))) >>> DW;
                    end
                    exp_q.push_back(acc[DW-1:0]);
                end
            end
        end
    end

    typedef struct {
        logic          load;
        logic          dv;
        logic [DW-1:0] din;
        logic          exp_ready;
        logic          exp_valid;
        logic [DW-1:0] exp_dout;
    } vec_t;

    vec_t imp_tbl [9];
    vec_t rel_tbl [4];

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        i_load_start = v.load;
        i_din_valid  = v.dv;
        iv_din       = v.din;
        @(negedge i_clk);
        check({tag, " din_ready"}, {31'd0, o_din_ready}, {31'd0, v.exp_ready});
        check({tag, " dout_valid"}, {31'd0, o_dout_valid}, {31'd0, v.exp_valid});
        if (v.exp_valid) check({tag, " dout"}, {24'd0, ov_dout}, {24'd0, v.exp_dout});
        tick();
        i_load_start = 1'b0;
        i_din_valid  = 1'b0;
    endtask

    task automatic pulse_load();
        i_load_start = 1'b1;
        tick();
        i_load_start = 1'b0;
    endtask

    task automatic load_words(input logic [DW-1:0] c [NT], input int nwords, input int gap,
                              input bit check_clear);
        int n;
        for (int i = 0; i < nwords; i++) begin
            i_coef_valid = 1'b1;
            iv_coef      = c[i];
            n = 0;
            while (o_coef_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            if (n >= 20) begin
                checks++;
                errors++;
                $display("FAIL coef_ready: got 0 for 20 cycles, expected 1");
                i_coef_valid = 1'b0;
                return;
            end
            check("din_ready_in_load", {31'd0, o_din_ready}, 32'd0);
            tick();
            i_coef_valid = 1'b0;
            if (i < nwords - 1) repeat (gap) tick();
        end
        if (nwords == NT) begin
            if (check_clear) begin
                check("tap_rst_in_clear", {31'd0, o_tap_rst}, 32'd1);
                check("din_ready_in_clear", {31'd0, o_din_ready}, 32'd0);
            end
            tick();
            if (check_clear) begin
                check("tap_rst_after_clear", {31'd0, o_tap_rst}, 32'd0);
                check("din_ready_after_clear", {31'd0, o_din_ready}, 32'd1);
            end
        end
    endtask

    task automatic check_weights(input string tag, input logic [DW-1:0] c [NT]);
        for (int k = 0; k < NT; k++) begin
            check($sformatf("%s weight%0d", tag, k), {24'd0, ov_weights[k*DW +: DW]},
                  {24'd0, c[k]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] cw [NT];
        logic [DW-1:0] zw [NT];
        logic [DW-1:0] rw [NT];
        int            pulses0;

        cw = '{8'd64, 8'd32, 8'd16, 8'd8};
        zw = '{8'd0, 8'd0, 8'd0, 8'd0};

        imp_tbl[0] = '{1'b0, 1'b1, 8'd64, 1'b1, 1'b0, 8'd0};
        imp_tbl[1] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b0, 8'd0};
        imp_tbl[2] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b0, 8'd0};
        imp_tbl[3] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b1, 8'd16};
        imp_tbl[4] = '{1'b0, 1'b1, 8'd0,  1'b1, 1'b1, 8'd8};
        imp_tbl[5] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 8'd4};
        imp_tbl[6] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 8'd2};
        imp_tbl[7] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b1, 8'd0};
        imp_tbl[8] = '{1'b0, 1'b0, 8'd0,  1'b1, 1'b0, 8'd0};

        rel_tbl[0] = '{1'b1, 1'b1, 8'd64, 1'b1, 1'b0, 8'd0};
        rel_tbl[1] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0};
        rel_tbl[2] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b0, 8'd0};
        rel_tbl[3] = '{1'b0, 1'b0, 8'd0,  1'b0, 1'b1, 8'd16};

        // Reset
        i_rst = 1'b1;
        repeat (2) tick();
        check("rst coef_ready", {31'd0, o_coef_ready}, 32'd0);
        check("rst din_ready", {31'd0, o_din_ready}, 32'd0);
        check("rst tap_en", {31'd0, o_tap_en}, 32'd0);
        check("rst tap_rst", {31'd0, o_tap_rst}, 32'd0);
        check("rst dout_valid", {31'd0, o_dout_valid}, 32'd0);
        check("rst dout", {24'd0, ov_dout}, 32'd0);
        check("rst tap_din", {24'd0, ov_tap_din}, 32'd0);
        check("rst weights", ov_weights, 32'd0);
        i_rst = 1'b0;
        tick();
        check("idle din_ready", {31'd0, o_din_ready}, 32'd0);

        // Load with one idle cycle between words
        pulses0 = rst_pulses;
        pulse_load();
        load_words(cw, NT, 1, 1'b1);
        check_weights("load", cw);
        check("tap_rst pulses", rst_pulses - pulses0, 32'd1);

        // Impulse
        for (int i = 0; i < 9; i++) run_vec(imp_tbl[i], $sformatf("impulse[%0d]", i));
`ifdef FIR_SEQ_SAMPLE_COUNT_EN
        check("sample_count after impulse", ov_sample_count, 32'd5);
`endif

        // Reload requested in the same cycle as a sample
        for (int i = 0; i < 4; i++) run_vec(rel_tbl[i], $sformatf("reload[%0d]", i));
        load_words(zw, NT, 0, 1'b1);
        check_weights("reload", zw);
`ifdef FIR_SEQ_SAMPLE_COUNT_EN
        check("sample_count after clear", ov_sample_count, 32'd0);
`endif
        i_din_valid = 1'b1;
        iv_din      = 8'd100;
        tick();
        i_din_valid = 1'b0;
        repeat (2) tick();
        check("zero-coef dout_valid", {31'd0, o_dout_valid}, 32'd1);
        check("zero-coef dout", {24'd0, ov_dout}, 32'd0);

        // Reset after two of four words
        pulse_load();
        load_words(cw, 2, 1, 1'b0);
        i_rst = 1'b1;
        tick();
        check("midload rst coef_ready", {31'd0, o_coef_ready}, 32'd0);
        check("midload rst din_ready", {31'd0, o_din_ready}, 32'd0);
        check("midload rst weights", ov_weights, 32'd0);
        i_rst = 1'b0;
        tick();
        pulses0 = rst_pulses;
        pulse_load();
        load_words(cw, NT, 1, 1'b1);
        check_weights("reload after rst", cw);
        check("tap_rst pulses after rst", rst_pulses - pulses0, 32'd1);

        // Reset with a sample in flight: no strobe may follow
        i_din_valid = 1'b1;
        iv_din      = 8'd50;
        tick();
        i_din_valid = 1'b0;
        i_rst       = 1'b1;
        tick();
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("no strobe after rst[%0d]", i), {31'd0, o_dout_valid}, 32'd0);
        end

        // Random coefficients and sample streams, reloads with samples in flight
        for (int it = 0; it < 6; it++) begin
            for (int k = 0; k < NT; k++) rw[k] = DW'($urandom);
            pulse_load();
            load_words(rw, NT, int'($urandom_range(0, 2)), 1'b0);
            check_weights($sformatf("rand%0d", it), rw);
            for (int c = 0; c < 30; c++) begin
                i_din_valid = ($urandom_range(0, 3) != 0);
                iv_din      = DW'($urandom);
                tick();
            end
            i_din_valid = 1'b0;
        end
        repeat (6) tick();
        check("expected queue drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
